// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32 multicycle control FSM with a retired-instruction counter.
// Define ILLEGAL_TRAP_EN to trap unknown opcodes into HALT and expose the TRAP port.
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      IR,
  input  logic             ZERO,
  input  logic             MEM_READY,
  output logic             MEM_RD,
  output logic             MEM_WR,
  output logic             IADR_SRC,
  output logic             IR_WE,
  output logic             PC_WE,
  output logic [1:0]       PC_SRC,
  output logic             REG_WE,
  output logic [1:0]       RESULT_SRC,
  output logic [1:0]       ALU_SRC_A,
  output logic             ALU_SRC_B,
  output logic [1:0]       ALU_OP,
  output logic [2:0]       STATE,
`ifdef ILLEGAL_TRAP_EN
  output logic             TRAP,
`endif
  output logic [CNT_W-1:0] INSTR_COUNT
);
  localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd5;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011, OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
  logic [2:0]       r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [6:0]       w_op;
  logic [2:0]       w_f3;
  logic             w_retire, w_legal, w_taken, w_unused;
  assign w_op = IR[6:0];
  assign w_f3 = IR[14:12];
  assign w_unused = ^{IR[31:15], IR[11:7]};
  assign w_legal = w_op inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
  assign w_taken = (w_f3 == 3'b000 && ZERO) || (w_f3 == 3'b001 && !ZERO);
  assign STATE = r_state;
  assign INSTR_COUNT = r_cnt;
`ifdef ILLEGAL_TRAP_EN
  assign TRAP = r_state == HALT;
`endif
  always_comb begin
    w_next = r_state;
    w_retire = 1'b0;
    MEM_RD = 1'b0;
    MEM_WR = 1'b0;
    IADR_SRC = 1'b0;
    IR_WE = 1'b0;
    PC_WE = 1'b0;
    PC_SRC = 2'b00;
    REG_WE = 1'b0;
    RESULT_SRC = 2'b00;
    ALU_SRC_A = 2'b00;
    ALU_SRC_B = 1'b0;
    ALU_OP = 2'b00;
    case (r_state)
      FETCH: begin
        MEM_RD = 1'b1;
        IR_WE = MEM_READY;
        PC_WE = MEM_READY;
        w_next = MEM_READY ? DECODE : FETCH;
      end
      DECODE: begin
        ALU_SRC_A = 2'b01;
        ALU_SRC_B = 1'b1;
`ifdef ILLEGAL_TRAP_EN
        w_next = w_legal ? EXEC : HALT;
`else
        w_next = w_legal ? EXEC : FETCH;
        w_retire = !w_legal;
`endif
      end
      EXEC: begin
        ALU_SRC_A = w_op == OP_LUI ? 2'b10 : w_op == OP_AUIPC ? 2'b01 : 2'b00;
        ALU_SRC_B = w_op inside {OP_I, OP_LD, OP_ST, OP_LUI, OP_AUIPC, OP_JALR};
        ALU_OP = w_op inside {OP_R, OP_I} ? 2'b10 : w_op == OP_BR ? 2'b01 : 2'b00;
        PC_WE = w_op inside {OP_JAL, OP_JALR} || (w_op == OP_BR && w_taken);
        PC_SRC = w_op == OP_JALR ? 2'b10 : PC_WE ? 2'b01 : 2'b00;
        w_next = w_op == OP_BR ? FETCH : w_op inside {OP_LD, OP_ST} ? MEM : WB;
        w_retire = w_op == OP_BR;
      end
      MEM: begin
        IADR_SRC = 1'b1;
        MEM_RD = w_op == OP_LD;
        MEM_WR = w_op == OP_ST;
        w_next = !MEM_READY ? MEM : w_op == OP_LD ? WB : FETCH;
        w_retire = MEM_READY && w_op != OP_LD;
      end
      WB: begin
        REG_WE = 1'b1;
        RESULT_SRC = w_op == OP_LD ? 2'b01 : w_op inside {OP_JAL, OP_JALR} ? 2'b10 : 2'b00;
        w_next = FETCH;
        w_retire = 1'b1;
      end
      HALT: w_next = HALT;
      default: w_next = FETCH;
    endcase
    if (rst) begin
      MEM_RD = 1'b0;
      MEM_WR = 1'b0;
      IR_WE = 1'b0;
      PC_WE = 1'b0;
      REG_WE = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH;
      r_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_cnt <= r_cnt + CNT_W'(w_retire);
    end
  end
endmodule
